// File: rtl/alsu_arbiter.sv
// alsu_arbiter: shares one two-stage ALSU between two requesters.
// A granted command is held on the ALSU inputs until the ALSU pipeline has
// produced its result. The result is captured once and returned on a shared
// valid/ready response channel, tagged with the id of the issuing requester.
module alsu_arbiter #(
   parameter string ARB_MODE = "RR",   // "RR" round-robin, "FIXED" req0 always wins
   parameter int    ALSU_LAT = 2       // ALSU edges from input change to out/leds update
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_cmd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_cmd,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [5:0]  rsp_out,
   output logic [15:0] rsp_leds,
   output logic        rsp_err,
   output logic [15:0] alsu_cmd,
   input  logic [5:0]  alsu_out,
   input  logic [15:0] alsu_leds,
   output logic        busy,
   output logic [15:0] op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int   CNT_W      = (ALSU_LAT < 1) ? 1 : $clog2(ALSU_LAT + 1);
   localparam logic FIXED_MODE = (ARB_MODE == "FIXED");

   logic [1:0]       state;
   logic [15:0]      cmd_reg;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;   // id of the most recently granted requester
   logic             grant0;
   logic             grant1;

   // Arbitration: in round-robin a tie goes to the requester not granted last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (FIXED_MODE) begin
         grant0 = req0_valid;
         grant1 = req1_valid & ~req0_valid;
      end else if (req0_valid & req1_valid) begin
         grant0 = last_grant;
         grant1 = ~last_grant;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;
   assign busy       = (state != IDLE);
   // Idle ALSU sees an all-zero command: AND of zeros, no bypass, no reduction.
   assign alsu_cmd   = (state == IDLE) ? 16'h0000 : cmd_reg;

   // Control FSM: accept, wait out the ALSU pipeline, capture, hand off response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cmd_reg    <= 16'h0000;
         cnt        <= '0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_out    <= 6'h00;
         rsp_leds   <= 16'h0000;
         rsp_err    <= 1'b0;
         op_count   <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 | grant1) begin
                  cmd_reg    <= grant0 ? req0_cmd : req1_cmd;
                  rsp_id     <= grant1;
                  last_grant <= grant1;
                  cnt        <= CNT_W'(ALSU_LAT);
                  state      <= WAIT;
               end
            end
            WAIT: begin
               // Capture happens on the edge after the counter reaches zero,
               // i.e. ALSU_LAT+1 edges after the accept edge.
               if (cnt == '0) begin
                  rsp_out   <= alsu_out;
                  rsp_leds  <= alsu_leds;
                  rsp_err   <= (alsu_leds != 16'h0000);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_valid & rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 16'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: table-driven and sequence checks of alsu_arbiter in both
// arbitration modes, with a behavioural two-stage ALSU behind each instance.
module tb_alsu_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Round-robin instance
   logic        r_req0_valid = 0, r_req1_valid = 0, r_rsp_ready = 1;
   logic [15:0] r_req0_cmd = '0, r_req1_cmd = '0;
   logic        r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_err, r_busy;
   logic [5:0]  r_rsp_out, r_alsu_out;
   logic [15:0] r_rsp_leds, r_alsu_cmd, r_alsu_leds, r_op_count;

   // Fixed-priority instance
   logic        f_req0_valid = 0, f_req1_valid = 0, f_rsp_ready = 1;
   logic [15:0] f_req0_cmd = '0, f_req1_cmd = '0;
   logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_err, f_busy;
   logic [5:0]  f_rsp_out, f_alsu_out;
   logic [15:0] f_rsp_leds, f_alsu_cmd, f_alsu_leds, f_op_count;

   alsu_arbiter #(.ARB_MODE("RR"), .ALSU_LAT(LAT)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r_req0_valid), .req0_ready(r_req0_ready), .req0_cmd(r_req0_cmd),
      .req1_valid(r_req1_valid), .req1_ready(r_req1_ready), .req1_cmd(r_req1_cmd),
      .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_id(r_rsp_id),
      .rsp_out(r_rsp_out), .rsp_leds(r_rsp_leds), .rsp_err(r_rsp_err),
      .alsu_cmd(r_alsu_cmd), .alsu_out(r_alsu_out), .alsu_leds(r_alsu_leds),
      .busy(r_busy), .op_count(r_op_count));

   alsu_arbiter #(.ARB_MODE("FIXED"), .ALSU_LAT(LAT)) dut_fx (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_cmd(f_req0_cmd),
      .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_cmd(f_req1_cmd),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
      .rsp_out(f_rsp_out), .rsp_leds(f_rsp_leds), .rsp_err(f_rsp_err),
      .alsu_cmd(f_alsu_cmd), .alsu_out(f_alsu_out), .alsu_leds(f_alsu_leds),
      .busy(f_busy), .op_count(f_op_count));

   // Behavioural ALSU: combinational ops only (AND, XOR, ADD, MUL, invalid).
   function automatic logic [5:0] ref_out(input logic [15:0] c);
      logic [2:0] a, b;
      a = c[12:10];
      b = c[9:7];
      case (c[15:13])
         3'd0:    return {3'b000, a & b};
         3'd1:    return {3'b000, a ^ b};
         3'd2:    return 6'(a) + 6'(b) + 6'(c[6]);
         3'd3:    return 6'(a) * 6'(b);
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [15:0] ref_leds(input logic [15:0] c);
      return (c[15:14] == 2'b11) ? 16'hFFFF : 16'h0000;
   endfunction

   logic [15:0] r_in_reg = '0, f_in_reg = '0;
   logic [5:0]  r_out_reg = '0, f_out_reg = '0;
   logic [15:0] r_led_reg = '0, f_led_reg = '0;
   always @(posedge clk) begin
      r_in_reg  <= r_alsu_cmd;
      r_out_reg <= ref_out(r_in_reg);
      r_led_reg <= ref_leds(r_in_reg);
      f_in_reg  <= f_alsu_cmd;
      f_out_reg <= ref_out(f_in_reg);
      f_led_reg <= ref_leds(f_in_reg);
   end
   assign r_alsu_out  = r_out_reg;
   assign r_alsu_leds = r_led_reg;
   assign f_alsu_out  = f_out_reg;
   assign f_alsu_leds = f_led_reg;

   typedef struct {
      logic        id;
      logic [5:0]  out;
      logic [15:0] leds;
      logic        err;
   } exp_t;

   typedef struct {
      logic        which;
      logic [15:0] cmd;
      logic [5:0]  out;
      logic [15:0] leds;
      logic        err;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[7];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic cin);
      return {op, a, b, cin, 6'b000000};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", r_busy, 0);
      chk("rst_rsp_valid", r_rsp_valid, 0);
      chk("rst_op_count", r_op_count, 0);
      chk("rst_alsu_cmd", r_alsu_cmd, 0);
      chk("rst_rsp_data", {r_rsp_id, r_rsp_err, r_rsp_out, r_rsp_leds}, 0);
      chk("rst_fx_busy", {f_busy, f_rsp_valid, f_op_count}, 0);
      rst_n = 1'b1;
      sb.delete();
      exp_cnt = 0;
      @(negedge clk);
   endtask

   // Present one command on the RR instance; returns at the negedge after the accept edge.
   task automatic issue(input logic which, input logic [15:0] cmd, input exp_t e);
      logic ok;
      ok = 1'b0;
      if (!which) begin r_req0_cmd = cmd; r_req0_valid = 1'b1; end
      else        begin r_req1_cmd = cmd; r_req1_valid = 1'b1; end
      #1;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (which ? r_req1_ready : r_req0_ready) ok = 1'b1;
         else begin @(negedge clk); #1; end
      end
      chk("accept_seen", ok, 1);
      if (ok) begin
         @(posedge clk);
         sb.push_back(e);
         #1;
      end
      r_req0_valid = 1'b0;
      r_req1_valid = 1'b0;
      @(negedge clk);
   endtask

   // Wait for a response, compare against the scoreboard, complete the handshake.
   task automatic wait_rsp(output int n);
      exp_t e;
      n = 0;
      while (!r_rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_seen", r_rsp_valid, 1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         $display("rsp id=%0d out=%h leds=%h err=%0d (exp id=%0d out=%h leds=%h err=%0d)",
                  r_rsp_id, r_rsp_out, r_rsp_leds, r_rsp_err, e.id, e.out, e.leds, e.err);
         chk("rsp_id", r_rsp_id, e.id);
         chk("rsp_out", r_rsp_out, e.out);
         chk("rsp_leds", r_rsp_leds, e.leds);
         chk("rsp_err", r_rsp_err, e.err);
      end
      r_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      chk("op_count", r_op_count, exp_cnt);
      chk("rsp_valid_drop", r_rsp_valid, 0);
   endtask

   initial begin
      exp_t        e;
      int          n;
      logic [15:0] c;
      logic [5:0]  h_out;
      logic [15:0] h_leds;
      logic        h_id, h_err;
      logic        ok;

      tbl[0] = '{1'b0, mk(3'd0, 3'd5, 3'd3, 1'b0), 6'h01, 16'h0000, 1'b0};
      tbl[1] = '{1'b1, mk(3'd2, 3'd7, 3'd7, 1'b1), 6'h0F, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, mk(3'd3, 3'd7, 3'd7, 1'b0), 6'h31, 16'h0000, 1'b0};
      tbl[3] = '{1'b1, mk(3'd6, 3'd1, 3'd2, 1'b0), 6'h00, 16'hFFFF, 1'b1};
      tbl[4] = '{1'b0, mk(3'd1, 3'd6, 3'd3, 1'b0), 6'h05, 16'h0000, 1'b0};
      tbl[5] = '{1'b1, mk(3'd2, 3'd5, 3'd6, 1'b0), 6'h0B, 16'h0000, 1'b0};
      tbl[6] = '{1'b0, mk(3'd7, 3'd0, 3'd0, 1'b0), 6'h00, 16'hFFFF, 1'b1};

      do_reset();

      // Invalid opcode straight after reset
      c = mk(3'd6, 3'd0, 3'd0, 1'b0);
      issue(1'b0, c, '{1'b0, 6'h00, 16'hFFFF, 1'b1});
      wait_rsp(n);

      // AND with latency: capture lands ALSU_LAT+1 edges after the accept edge
      c = mk(3'd0, 3'd5, 3'd3, 1'b0);
      issue(1'b0, c, '{1'b0, 6'h01, 16'h0000, 1'b0});
      chk("wait_busy", r_busy, 1);
      chk("wait_alsu_cmd", r_alsu_cmd, c);
      wait_rsp(n);
      chk("capture_latency", n, LAT + 1);
      chk("idle_alsu_cmd", r_alsu_cmd, 0);

      // Vector table
      for (int i = 0; i < 7; i++) begin
         issue(tbl[i].which, tbl[i].cmd, '{tbl[i].which, tbl[i].out, tbl[i].leds, tbl[i].err});
         wait_rsp(n);
      end

      // Consumer stall: response held, no new accept, op_count waits for handshake
      r_rsp_ready = 1'b0;
      c = mk(3'd2, 3'd3, 3'd4, 1'b0);
      issue(1'b0, c, '{1'b0, 6'h07, 16'h0000, 1'b0});
      r_req1_cmd = mk(3'd0, 3'd7, 3'd7, 1'b0);
      r_req1_valid = 1'b1;
      for (int i = 0; i < 30 && !r_rsp_valid; i++) @(negedge clk);
      h_out = r_rsp_out; h_leds = r_rsp_leds; h_id = r_rsp_id; h_err = r_rsp_err;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", r_rsp_valid, 1);
         chk("stall_hold", {r_rsp_id, r_rsp_err, r_rsp_out, r_rsp_leds}, {h_id, h_err, h_out, h_leds});
         chk("stall_ready", {r_req0_ready, r_req1_ready}, 0);
         chk("stall_count", r_op_count, exp_cnt);
      end
      r_req1_valid = 1'b0;
      wait_rsp(n);

      // Round-robin with both requesters always valid
      do_reset();
      r_req0_cmd = mk(3'd0, 3'd5, 3'd3, 1'b0);
      r_req1_cmd = mk(3'd2, 3'd7, 3'd7, 1'b1);
      r_req0_valid = 1'b1;
      r_req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 30 && !ok; i++) begin
            #1;
            if (r_req0_ready | r_req1_ready) ok = 1'b1;
            else @(negedge clk);
         end
         chk("rr_accept_seen", ok, 1);
         chk("rr_onehot", r_req0_ready & r_req1_ready, 0);
         chk("rr_id", r_req1_ready, k % 2);
         if (r_req1_ready) e = '{1'b1, 6'h0F, 16'h0000, 1'b0};
         else              e = '{1'b0, 6'h01, 16'h0000, 1'b0};
         @(posedge clk);
         sb.push_back(e);
         @(negedge clk);
         wait_rsp(n);
      end
      r_req0_valid = 1'b0;
      r_req1_valid = 1'b0;

      // Fixed priority with both requesters always valid
      f_req0_cmd = mk(3'd1, 3'd1, 3'd2, 1'b0);
      f_req1_cmd = mk(3'd3, 3'd2, 3'd3, 1'b0);
      f_req0_valid = 1'b1;
      f_req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 30 && !ok; i++) begin
            #1;
            if (f_req0_ready | f_req1_ready) ok = 1'b1;
            else @(negedge clk);
         end
         chk("fx_accept_seen", ok, 1);
         chk("fx_grant", {f_req1_ready, f_req0_ready}, 2'b01);
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < 30 && !f_rsp_valid; i++) @(negedge clk);
         chk("fx_rsp_valid", f_rsp_valid, 1);
         chk("fx_rsp_id", f_rsp_id, 0);
         chk("fx_rsp_out", f_rsp_out, 6'h03);
         $display("fx rsp id=%0d out=%h", f_rsp_id, f_rsp_out);
         @(posedge clk);
         @(negedge clk);
      end
      f_req0_valid = 1'b0;
      f_req1_valid = 1'b0;
      @(negedge clk);
      chk("fx_op_count", f_op_count, 4);

      // Reset while waiting on the ALSU discards the command
      r_req1_valid = 1'b1;
      r_req1_cmd = mk(3'd3, 3'd5, 3'd5, 1'b0);
      #1;
      chk("pre_rst_grant", {r_req1_ready, r_req0_ready}, 2'b10);
      @(posedge clk);
      #1;
      r_req1_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", r_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", r_busy, 0);
      chk("midrst_rsp_valid", r_rsp_valid, 0);
      chk("midrst_op_count", r_op_count, 0);
      chk("midrst_alsu_cmd", r_alsu_cmd, 0);
      $display("reset during WAIT: busy=%0d op_count=%0d", r_busy, r_op_count);
      sb.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", r_rsp_valid, 0);
      end
      r_req0_cmd = mk(3'd0, 3'd7, 3'd6, 1'b0);
      r_req1_cmd = mk(3'd1, 3'd7, 3'd6, 1'b0);
      r_req0_valid = 1'b1;
      r_req1_valid = 1'b1;
      #1;
      chk("post_rst_grant", {r_req1_ready, r_req0_ready}, 2'b01);
      @(posedge clk);
      sb.push_back('{1'b0, 6'h06, 16'h0000, 1'b0});
      #1;
      r_req0_valid = 1'b0;
      r_req1_valid = 1'b0;
      @(negedge clk);
      wait_rsp(n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
